// File: rtl/clk_divider_pkg.sv
// -----------------------------------------------------------------------------
// clk_divider_pkg
//   Shared definitions for the programmable clock generator: output mode
//   encoding and default counter widths.
// -----------------------------------------------------------------------------
package clk_divider_pkg;

    localparam int unsigned DEF_COUNTER_BITS = 32;
    localparam int unsigned DEF_PULSE_BITS   = 32;

    // Value of the 'option' input selecting the output mode.
    typedef enum logic {
        MODE_BURST = 1'b0,
        MODE_FREE  = 1'b1
    } mode_e;

endpackage

// File: rtl/clk_divider_clk_gate.sv
// -----------------------------------------------------------------------------
// clk_gate
//   Glitch-free clock gate: a gate register that only updates while the
//   source clock is low, ANDed with the source clock.
// Ports
//   i_clk    sampling clock for the gate register
//   i_rst    asynchronous active-high reset (gate closed)
//   i_sample qualifier: gate register loads i_en only when high
//   i_en     requested gate state
//   i_src    clock being gated
//   o_gate   current gate register value
//   o_clk    gated clock (i_src & o_gate)
// Parameters
//   SAMPLE_NEGEDGE  1: gate register updates on negedge i_clk, 0: on posedge
// -----------------------------------------------------------------------------
module clk_gate
    import clk_divider_pkg::*;
#(
    parameter bit SAMPLE_NEGEDGE = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sample,
    input  logic i_en,
    input  logic i_src,
    output logic o_gate,
    output logic o_clk
);

    logic r_gate;

    generate
        if (SAMPLE_NEGEDGE) begin : g_neg
            always_ff @(negedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_gate <= 1'b0;
                end else if (i_sample) begin
                    r_gate <= i_en;
                end
            end
        end else begin : g_pos
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_gate <= 1'b0;
                end else if (i_sample) begin
                    r_gate <= i_en;
                end
            end
        end
    endgenerate

    assign o_gate = r_gate;
    assign o_clk  = i_src & r_gate;

endmodule

// File: rtl/clk_divider.sv
// -----------------------------------------------------------------------------
// clk_divider
//   Programmable gated clock generator. Divides clk by 2*divider (or passes
//   clk through when divider==0) and gates the result either continuously
//   (free-running) or for exactly 'pulse' output rising edges (burst).
// Ports
//   clk          source clock
//   reset        asynchronous active-high reset
//   option       1 = free-running, 0 = burst
//   write_pulse  1-cycle strobe loading 'pulse' into the remaining counter
//   out_enable   global gate; 0 holds clk_o low (burst count paused)
//   divider      half-period in clk cycles, 0 = bypass
//   pulse        number of clk_o rising edges per burst
//   clk_o        generated clock
// -----------------------------------------------------------------------------
module clk_divider
    import clk_divider_pkg::*;
#(
    parameter int unsigned COUNTER_BITS = DEF_COUNTER_BITS,
    parameter int unsigned PULSE_BITS   = DEF_PULSE_BITS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    option,
    input  logic                    write_pulse,
    input  logic                    out_enable,
    input  logic [COUNTER_BITS-1:0] divider,
    input  logic [PULSE_BITS-1:0]   pulse,
    output logic                    clk_o
);

    logic [COUNTER_BITS-1:0] r_cnt;
    logic                    r_div_clk;
    logic [PULSE_BITS-1:0]   r_remaining;

    logic w_bypass;
    logic w_wrap;
    logic w_div_next;
    logic w_div_rise;
    logic w_en;
    logic w_edge;
    logic w_gate_byp;
    logic w_gate_div;
    logic w_clk_byp;
    logic w_clk_div;

    assign w_bypass = (divider == '0);

    // >= so that shrinking the divider below the current count wraps at once.
    assign w_wrap     = !w_bypass && (r_cnt >= (divider - COUNTER_BITS'(1)));
    assign w_div_next = w_wrap ? ~r_div_clk : r_div_clk;
    assign w_div_rise = w_wrap & ~r_div_clk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_div_clk <= 1'b0;
        end else if (w_bypass) begin
            r_cnt     <= '0;
            r_div_clk <= 1'b0;
        end else if (w_wrap) begin
            r_cnt     <= '0;
            r_div_clk <= ~r_div_clk;
        end else begin
            r_cnt     <= r_cnt + COUNTER_BITS'(1);
        end
    end

    assign w_en = out_enable & ((option == MODE_FREE) | (r_remaining != '0));

    // Separate gates per source: the bypass path can only be gated safely on
    // the falling edge of clk, while the divided path is gated on the rising
    // clk edge that leaves div_clk low. The unused path's gate is ignored.
    clk_gate #(.SAMPLE_NEGEDGE(1'b1)) u_gate_byp (
        .i_clk    (clk),
        .i_rst    (reset),
        .i_sample (1'b1),
        .i_en     (w_en),
        .i_src    (clk),
        .o_gate   (w_gate_byp),
        .o_clk    (w_clk_byp)
    );

    clk_gate #(.SAMPLE_NEGEDGE(1'b0)) u_gate_div (
        .i_clk    (clk),
        .i_rst    (reset),
        .i_sample (~w_div_next),
        .i_en     (w_en),
        .i_src    (r_div_clk),
        .o_gate   (w_gate_div),
        .o_clk    (w_clk_div)
    );

    // A clk_o rising edge happens on this posedge clk.
    assign w_edge = w_bypass ? w_gate_byp : (w_div_rise & w_gate_div);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_remaining <= '0;
        end else if (write_pulse) begin
            r_remaining <= pulse;
        end else if (w_edge && (r_remaining != '0)) begin
            r_remaining <= r_remaining - PULSE_BITS'(1);
        end
    end

    assign clk_o = w_bypass ? w_clk_byp : w_clk_div;

endmodule

// File: tb/tb_clk_divider.sv
`timescale 100ps/100ps
module tb_clk_divider;

    localparam int unsigned CB = 32;
    localparam int unsigned PB = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          option = 1'b1;
    logic          write_pulse = 1'b0;
    logic          out_enable = 1'b1;
    logic [CB-1:0] divider = '0;
    logic [PB-1:0] pulse = '0;
    logic          clk_o;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    // clk_o monitor (times in 100ps units; clk period = 20)
    int     rises = 0;
    longint t_rise = 0;
    bit     have_rise = 1'b0;
    int     last_high = 0;
    int     last_period = 0;
    int     min_high = 1 << 30;
    int     base;

    clk_divider #(.COUNTER_BITS(CB), .PULSE_BITS(PB)) dut (
        .clk         (clk),
        .reset       (reset),
        .option      (option),
        .write_pulse (write_pulse),
        .out_enable  (out_enable),
        .divider     (divider),
        .pulse       (pulse),
        .clk_o       (clk_o)
    );

    always #10 clk = ~clk;

    always @(posedge clk_o) begin
        if (have_rise) last_period = int'($time - t_rise);
        t_rise    = $time;
        have_rise = 1'b1;
        rises++;
    end

    always @(negedge clk_o) begin
        if (have_rise) begin
            last_high = int'($time - t_rise);
            if (last_high < min_high) min_high = last_high;
        end
    end

    task automatic clear_mon();
        rises       = 0;
        have_rise   = 1'b0;
        last_high   = 0;
        last_period = 0;
        min_high    = 1 << 30;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        int exp;
        if (exp_q.size() == 0) exp = -1;
        else exp = exp_q.pop_front();
        checks++;
        assert (obs === 32'(exp)) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load(input int n);
        pulse       = PB'(n);
        write_pulse = 1'b1;
        step(1);
        write_pulse = 1'b0;
    endtask

    task automatic wait_rises(input int target, input int budget);
        for (int i = 0; i < budget && rises < target; i++) step(1);
    endtask

    initial begin
        // Reset held with output enabled in free-running bypass mode
        #1;
        reset = 1'b1;
        clear_mon();
        step(5);
        exp_q.push_back(0); check("reset_rises", rises);
        exp_q.push_back(0); check("reset_clk_o", {31'b0, clk_o});

        // Bypass free-run: 30ns on, 30ns off, 40ns on
        reset = 1'b0;
        clear_mon();
        exp_q.push_back(15);
        step(15);
        check("byp_on_rises", rises);
        out_enable = 1'b0;
        clear_mon();
        exp_q.push_back(0);
        step(15);
        check("byp_off_rises", rises);
        out_enable = 1'b1;
        clear_mon();
        exp_q.push_back(20);
        step(20);
        check("byp_on2_rises", rises);
        exp_q.push_back(10); check("byp_min_high", min_high);

        // Divide by 3: period 6 cycles, 3 high
        out_enable = 1'b0;
        step(3);
        divider = CB'(3);
        step(6);
        out_enable = 1'b1;
        step(12);
        clear_mon();
        exp_q.push_back(4);
        step(24);
        check("div3_rises", rises);
        exp_q.push_back(120); check("div3_period", last_period);
        exp_q.push_back(60);  check("div3_high", last_high);

        // Divide by 1: period 2 cycles
        divider = CB'(1);
        step(8);
        clear_mon();
        exp_q.push_back(5);
        step(10);
        check("div1_rises", rises);
        exp_q.push_back(40); check("div1_period", last_period);
        exp_q.push_back(20); check("div1_high", last_high);

        // Burst mode, nothing loaded: no output
        option  = 1'b0;
        divider = CB'(2);
        step(10);
        clear_mon();
        exp_q.push_back(0);
        step(10);
        check("burst_idle", rises);

        // Burst of 5
        clear_mon();
        load(5);
        exp_q.push_back(5);
        step(40);
        check("burst5_rises", rises);
        exp_q.push_back(40); check("burst5_high", last_high);

        // pulse=0 emits nothing
        clear_mon();
        load(0);
        exp_q.push_back(0);
        step(20);
        check("burst0_rises", rises);

        // Pause mid-burst
        clear_mon();
        load(6);
        exp_q.push_back(2);
        wait_rises(2, 40);
        check("pause_pre", rises);
        out_enable = 1'b0;
        base = rises;
        exp_q.push_back(0);
        step(10);
        check("pause_hold", rises - base);
        out_enable = 1'b1;
        exp_q.push_back(6);
        step(40);
        check("pause_total", rises);

        // Reload mid-burst
        clear_mon();
        load(8);
        exp_q.push_back(3);
        wait_rises(3, 60);
        check("reload_pre", rises);
        load(2);
        exp_q.push_back(5);
        step(40);
        check("reload_total", rises);

        // Async reset mid-burst
        clear_mon();
        load(10);
        exp_q.push_back(1);
        for (int i = 0; i < 20 && clk_o !== 1'b1; i++) step(1);
        check("rst_pre_high", {31'b0, clk_o});
        #3;
        reset = 1'b1;
        exp_q.push_back(0);
        #1;
        check("rst_clk_o", {31'b0, clk_o});
        step(3);
        reset = 1'b0;
        clear_mon();
        exp_q.push_back(0);
        step(30);
        check("rst_after_rises", rises);
        clear_mon();
        load(3);
        exp_q.push_back(3);
        step(30);
        check("rst_new_burst", rises);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
